// File: rtl/holy_no_cache_wbuf.sv
// holy_no_cache_wbuf: uncached load/store bridge to AXI-Lite with a
// posted-write FIFO, strict read-after-write ordering and error reporting.
module holy_no_cache_wbuf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WBUF_DEPTH = 4,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [STRB_WIDTH-1:0] byte_enable,
  input  logic                  req_valid,
  input  logic                  req_write,
  output logic                  req_ready,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  input  logic                  read_ack,
  output logic                  idle,
  output logic                  error_valid,
  output logic                  error_write,
  output logic [ADDR_WIDTH-1:0] error_addr,
  output logic [ADDR_WIDTH-1:0] axi_lite_awaddr,
  output logic                  axi_lite_awvalid,
  input  logic                  axi_lite_awready,
  output logic [DATA_WIDTH-1:0] axi_lite_wdata,
  output logic [STRB_WIDTH-1:0] axi_lite_wstrb,
  output logic                  axi_lite_wvalid,
  input  logic                  axi_lite_wready,
  input  logic [1:0]            axi_lite_bresp,
  input  logic                  axi_lite_bvalid,
  output logic                  axi_lite_bready,
  output logic [ADDR_WIDTH-1:0] axi_lite_araddr,
  output logic                  axi_lite_arvalid,
  input  logic                  axi_lite_arready,
  input  logic [DATA_WIDTH-1:0] axi_lite_rdata,
  input  logic [1:0]            axi_lite_rresp,
  input  logic                  axi_lite_rvalid,
  output logic                  axi_lite_rready
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_WRESP = 3'd2;
  localparam logic [2:0] ST_RADDR = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_valid_q, err_valid_d;
  logic                  err_write_q, err_write_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  logic [ADDR_WIDTH-1:0] fifo_addr [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [WBUF_DEPTH];
  logic [STRB_WIDTH-1:0] fifo_strb [WBUF_DEPTH];

  logic [PTR_W-1:0]      wr_idx;
  logic [PTR_W-1:0]      rd_idx;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic                  take_load;

  assign wr_idx     = wr_ptr_q[PTR_W-1:0];
  assign rd_idx     = rd_ptr_q[PTR_W-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W])
                   && (wr_idx == rd_idx);

  assign req_ready = !rst && !rd_pend_q && !rvalid_q && !fifo_full;
  assign push      = req_valid && req_ready && req_write;
  assign take_load = req_valid && req_ready && !req_write;

  assign axi_lite_awaddr  = fifo_addr[rd_idx];
  assign axi_lite_wdata   = fifo_data[rd_idx];
  assign axi_lite_wstrb   = fifo_strb[rd_idx];
  assign axi_lite_awvalid = (state_q == ST_WRITE) && !aw_done_q;
  assign axi_lite_wvalid  = (state_q == ST_WRITE) && !w_done_q;
  assign axi_lite_bready  = (state_q == ST_WRESP);
  assign axi_lite_araddr  = rd_addr_q;
  assign axi_lite_arvalid = (state_q == ST_RADDR);
  assign axi_lite_rready  = (state_q == ST_RDATA);

  assign read_data   = rdata_q;
  assign read_valid  = rvalid_q;
  assign error_valid = err_valid_q;
  assign error_write = err_write_q;
  assign error_addr  = err_addr_q;
  assign idle        = fifo_empty && !rd_pend_q && (state_q == ST_IDLE);

  // Entry storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_idx] <= address;
      fifo_data[wr_idx] <= write_data;
      fifo_strb[wr_idx] <= byte_enable;
    end
  end

  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    pop         = 1'b0;
    rd_pend_d   = rd_pend_q || take_load;
    rd_addr_d   = take_load ? address : rd_addr_q;
    rvalid_d    = rvalid_q && !read_ack;
    rdata_d     = rdata_q;
    err_valid_d = 1'b0;
    err_write_d = err_write_q;
    err_addr_d  = err_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        // A same-cycle push is seen so a store issues one cycle later.
        if (!fifo_empty || push) begin
          state_d   = ST_WRITE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else if (rd_pend_q || take_load) begin
          state_d = ST_RADDR;
        end
      end
      ST_WRITE: begin
        if (axi_lite_awvalid && axi_lite_awready) aw_done_d = 1'b1;
        if (axi_lite_wvalid && axi_lite_wready) w_done_d = 1'b1;
        if (aw_done_d && w_done_d) state_d = ST_WRESP;
      end
      ST_WRESP: begin
        if (axi_lite_bvalid) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
          if (axi_lite_bresp != 2'b00) begin
            err_valid_d = 1'b1;
            err_write_d = 1'b1;
            err_addr_d  = fifo_addr[rd_idx];
          end
        end
      end
      ST_RADDR: begin
        if (axi_lite_arready) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (axi_lite_rvalid) begin
          rdata_d   = axi_lite_rdata;
          rvalid_d  = 1'b1;
          rd_pend_d = 1'b0;
          state_d   = ST_IDLE;
          if (axi_lite_rresp != 2'b00) begin
            err_valid_d = 1'b1;
            err_write_d = 1'b0;
            err_addr_d  = rd_addr_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      err_valid_q <= 1'b0;
      err_write_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rd_pend_q   <= rd_pend_d;
      rd_addr_q   <= rd_addr_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      err_valid_q <= err_valid_d;
      err_write_q <= err_write_d;
      err_addr_q  <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_holy_no_cache_wbuf.sv
// tb_holy_no_cache_wbuf: scenario tasks plus randomized traffic against
// an AXI-Lite slave and a flat memory reference model.
module tb_holy_no_cache_wbuf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [3:0]  byte_enable = '0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        req_ready;
  logic [31:0] read_data;
  logic        read_valid;
  logic        read_ack = 1'b0;
  logic        idle;
  logic        error_valid;
  logic        error_write;
  logic [31:0] error_addr;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;

  int n_checks = 0;
  int n_fail = 0;
  int wlog_cnt = 0;

  bit s_rnd = 0;
  bit aw_hold = 0;
  bit s_manual = 0;
  logic s_awready = 1'b0;
  logic s_wready = 1'b0;
  logic m_awready = 1'b0;
  logic m_wready = 1'b0;

  logic [31:0] smem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] aw_q [$];
  logic [35:0] w_q [$];
  logic [67:0] exp_w [$];
  logic [32:0] exp_err [$];

  assign awready = s_manual ? m_awready : s_awready;
  assign wready  = s_manual ? m_wready : s_wready;

  always #5 clk = ~clk;

  holy_no_cache_wbuf #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .WBUF_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .address(address), .write_data(write_data),
    .byte_enable(byte_enable), .req_valid(req_valid),
    .req_write(req_write), .req_ready(req_ready),
    .read_data(read_data), .read_valid(read_valid),
    .read_ack(read_ack), .idle(idle),
    .error_valid(error_valid), .error_write(error_write),
    .error_addr(error_addr),
    .axi_lite_awaddr(awaddr), .axi_lite_awvalid(awvalid),
    .axi_lite_awready(awready),
    .axi_lite_wdata(wdata), .axi_lite_wstrb(wstrb),
    .axi_lite_wvalid(wvalid), .axi_lite_wready(wready),
    .axi_lite_bresp(bresp), .axi_lite_bvalid(bvalid),
    .axi_lite_bready(bready),
    .axi_lite_araddr(araddr), .axi_lite_arvalid(arvalid),
    .axi_lite_arready(arready),
    .axi_lite_rdata(rdata), .axi_lite_rresp(rresp),
    .axi_lite_rvalid(rvalid), .axi_lite_rready(rready)
  );

  // Slave policy: 0x40..0x7F answers writes with SLVERR,
  // 0x80..0xBF answers reads with DECERR.
  function automatic bit err_w(input logic [31:0] a);
    return a[31:6] == 26'd1;
  endfunction

  function automatic bit err_r(input logic [31:0] a);
    return a[31:6] == 26'd2;
  endfunction

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic void model_accept(input bit wr,
                                       input logic [31:0] a,
                                       input logic [31:0] d,
                                       input logic [3:0] s,
                                       output logic [31:0] exp_rd);
    logic [31:0] old;
    old = ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
    exp_rd = old;
    if (wr) begin
      ref_mem[a] = merge(old, d, s);
      exp_w.push_back({a, d, s});
      if (err_w(a)) exp_err.push_back({1'b1, a});
    end else if (err_r(a)) begin
      exp_err.push_back({1'b0, a});
    end
  endfunction

  initial begin : slave
    logic [31:0] a;
    logic [35:0] dw;
    logic [67:0] e;
    logic [31:0] ar_addr;
    bit ar_pend;
    bit b_clr;
    bit r_clr;
    ar_pend = 0;
    ar_addr = '0;
    forever begin
      @(negedge clk);
      b_clr = 0;
      r_clr = 0;
      if (rst) begin
        aw_q.delete();
        w_q.delete();
        ar_pend = 0;
        b_clr = 1;
        r_clr = 1;
      end else begin
        if (awvalid && awready) aw_q.push_back(awaddr);
        if (wvalid && wready) w_q.push_back({wdata, wstrb});
        if (bvalid && bready) begin
          b_clr = 1;
          n_checks++;
          if (aw_q.size() == 0 || w_q.size() == 0) begin
            n_fail++;
            $display("FAIL b_without_aw_w aw=%0d w=%0d required both>0",
                     aw_q.size(), w_q.size());
          end else begin
            a = aw_q.pop_front();
            dw = w_q.pop_front();
            if (exp_w.size() == 0) begin
              n_fail++;
              $display("FAIL write_order got=%h none expected", {a, dw});
            end else begin
              e = exp_w.pop_front();
              if ({a, dw} !== e) begin
                n_fail++;
                $display("FAIL write_order got=%h required=%h", {a, dw}, e);
              end
            end
            smem[a] = merge(smem.exists(a) ? smem[a] : mem_default(a),
                            dw[35:4], dw[3:0]);
            wlog_cnt++;
          end
        end
        if (arvalid && arready) begin
          ar_addr = araddr;
          ar_pend = 1;
        end
        if (rvalid && rready) r_clr = 1;
      end
      @(posedge clk);
      #1;
      if (b_clr) bvalid = 1'b0;
      if (r_clr) rvalid = 1'b0;
      if (!rst && !bvalid && aw_q.size() > 0 && w_q.size() > 0
          && (!s_rnd || $urandom_range(2) == 0)) begin
        bvalid = 1'b1;
        bresp = err_w(aw_q[0]) ? 2'b10 : 2'b00;
      end
      if (!rst && !rvalid && ar_pend
          && (!s_rnd || $urandom_range(2) == 0)) begin
        rvalid = 1'b1;
        rdata = smem.exists(ar_addr) ? smem[ar_addr] : mem_default(ar_addr);
        rresp = err_r(ar_addr) ? 2'b11 : 2'b00;
        ar_pend = 0;
      end
      s_awready = !aw_hold && (!s_rnd || $urandom_range(1) == 0);
      s_wready = !s_rnd || $urandom_range(1) == 0;
      arready = !s_rnd || $urandom_range(1) == 0;
    end
  end

  initial begin : err_monitor
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst && error_valid === 1'b1) begin
        n_checks++;
        if (exp_err.size() == 0) begin
          n_fail++;
          $display("FAIL err_unexpected write=%b addr=%h required=none",
                   error_write, error_addr);
        end else begin
          e = exp_err.pop_front();
          if ({error_write, error_addr} !== e) begin
            n_fail++;
            $display("FAIL err_report got=%h required=%h",
                     {error_write, error_addr}, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  task automatic cpu_issue(input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] exp_rd);
    int n;
    n = 0;
    exp_rd = '0;
    req_valid = 1'b1;
    req_write = wr;
    address = a;
    write_data = d;
    byte_enable = s;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_timeout addr=%h req_ready=%b required=1",
               a, req_ready);
    end else begin
      model_accept(wr, a, d, s, exp_rd);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_read(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (read_valid !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    ok = (read_valid === 1'b1);
  endtask

  task automatic ack_read();
    @(posedge clk);
    #1;
    read_ack = 1'b1;
    @(posedge clk);
    #1;
    read_ack = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (idle !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (idle !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle=%b required=1", tag, idle);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] got;
    repeat (3) @(negedge clk);
    got = {awvalid, wvalid, bready, arvalid, rready, req_ready,
           read_valid, error_valid, idle, |read_data, |error_addr};
    n_checks++;
    if (got !== 11'b00000000100) begin
      n_fail++;
      $display("FAIL reset_state got=%b required=00000000100", got);
    end
    #2;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || idle !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release ready=%b idle=%b required=1 1",
               req_ready, idle);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_load();
    s_rnd = 0;
    smem[32'h1000] = 32'hDEADBEEF;
    ref_mem[32'h1000] = 32'hDEADBEEF;
    req_valid = 1'b1;
    req_write = 1'b0;
    address = 32'h1000;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_accept req_ready=%b required=1", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h1000) begin
      n_fail++;
      $display("FAIL load_ar_t1 arvalid=%b araddr=%h required=1 00001000",
               arvalid, araddr);
    end
    @(negedge clk);
    n_checks++;
    if (arvalid !== 1'b0 || rready !== 1'b1 || read_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL load_r_t2 ar=%b rr=%b rv=%b required=0 1 0",
               arvalid, rready, read_valid);
    end
    @(negedge clk);
    n_checks++;
    if (read_valid !== 1'b1 || read_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL load_data_t3 rv=%b data=%h required=1 deadbeef",
               read_valid, read_data);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (read_valid !== 1'b1 || read_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL load_hold rv=%b data=%h required=1 deadbeef",
               read_valid, read_data);
    end
    ack_read();
    @(negedge clk);
    n_checks++;
    if (read_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL load_ack_clear rv=%b required=0", read_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_posted_burst();
    logic [31:0] x;
    int base;
    s_rnd = 0;
    aw_hold = 1;
    @(posedge clk);
    #1;
    base = wlog_cnt;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      address = 32'(i * 4);
      write_data = 32'(i + 1);
      byte_enable = 4'hF;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL burst_accept_%0d req_ready=%b required=1",
                 i, req_ready);
      end else begin
        model_accept(1'b1, address, write_data, byte_enable, x);
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0 || awvalid !== 1'b1 || wlog_cnt != base) begin
      n_fail++;
      $display("FAIL burst_full ready=%b awvalid=%b writes=%0d req=0 1 %0d",
               req_ready, awvalid, wlog_cnt - base, 0);
    end
    @(posedge clk);
    #1;
    aw_hold = 0;
    wait_idle("burst_drain");
    n_checks++;
    if (wlog_cnt - base != 4 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_done writes=%0d ready=%b required=4 1",
               wlog_cnt - base, req_ready);
    end
  endtask

  task automatic test_raw();
    logic [31:0] x;
    bit bseen;
    bit early;
    int n;
    s_rnd = 1;
    cpu_issue(1'b1, 32'h20, 32'h55, 4'hF, x);
    cpu_issue(1'b0, 32'h20, 32'h0, 4'h0, x);
    bseen = 0;
    early = 0;
    n = 0;
    @(negedge clk);
    while (read_valid !== 1'b1 && n < 500) begin
      if (arvalid === 1'b1 && !bseen) early = 1;
      if (bvalid && bready) bseen = 1;
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (early || !bseen) begin
      n_fail++;
      $display("FAIL raw_order ar_before_b=%b b_seen=%b required=0 1",
               early, bseen);
    end
    n_checks++;
    if (read_valid !== 1'b1 || read_data !== 32'h55) begin
      n_fail++;
      $display("FAIL raw_data rv=%b data=%h required=1 00000055",
               read_valid, read_data);
    end
    ack_read();
    s_rnd = 0;
    wait_idle("raw_idle");
  endtask

  task automatic test_split();
    logic [31:0] x;
    s_rnd = 0;
    s_manual = 1;
    m_awready = 1'b1;
    m_wready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    address = 32'h30;
    write_data = $urandom;
    byte_enable = 4'hF;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL split_accept req_ready=%b required=1", req_ready);
    end else begin
      model_accept(1'b1, address, write_data, byte_enable, x);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL split_rise aw=%b w=%b required=1 1", awvalid, wvalid);
    end
    @(posedge clk);
    #1;
    m_awready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) m_wready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (awvalid !== 1'b0 || wvalid !== 1'b1 || bready !== 1'b0) begin
        n_fail++;
        $display("FAIL split_hold_%0d aw=%b w=%b b=%b required=0 1 0",
                 k, awvalid, wvalid, bready);
      end
      @(posedge clk);
      #1;
    end
    m_wready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b1) begin
      n_fail++;
      $display("FAIL split_bready aw=%b w=%b b=%b required=0 0 1",
               awvalid, wvalid, bready);
    end
    @(posedge clk);
    #1;
    s_manual = 0;
    wait_idle("split_idle");
  endtask

  task automatic test_errors();
    logic [31:0] exp;
    bit ok;
    int n;
    s_rnd = 0;
    cpu_issue(1'b1, 32'h40, $urandom, 4'hF, exp);
    n = 0;
    @(negedge clk);
    while (error_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (error_valid !== 1'b1 || error_write !== 1'b1
        || error_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL err_write ev=%b ew=%b ea=%h required=1 1 00000040",
               error_valid, error_write, error_addr);
    end
    @(negedge clk);
    n_checks++;
    if (error_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse_width ev=%b required=0", error_valid);
    end
    @(posedge clk);
    #1;
    cpu_issue(1'b0, 32'h80, 32'h0, 4'h0, exp);
    wait_read(ok);
    n_checks++;
    if (!ok || error_valid !== 1'b1 || error_write !== 1'b0
        || error_addr !== 32'h80) begin
      n_fail++;
      $display("FAIL err_read rv=%b ev=%b ew=%b ea=%h required=1 1 0 80",
               read_valid, error_valid, error_write, error_addr);
    end
    n_checks++;
    if (read_data !== exp) begin
      n_fail++;
      $display("FAIL err_read_data got=%h required=%h", read_data, exp);
    end
    ack_read();
    wait_idle("err_idle");
  endtask

  task automatic test_reset_mid();
    logic [31:0] saved [logic [31:0]];
    logic [31:0] x;
    int base;
    bit act;
    s_rnd = 0;
    aw_hold = 1;
    saved = ref_mem;
    @(posedge clk);
    #1;
    base = wlog_cnt;
    cpu_issue(1'b1, 32'h10, 32'hA1, 4'hF, x);
    cpu_issue(1'b1, 32'h14, 32'hA2, 4'hF, x);
    @(negedge clk);
    n_checks++;
    if (awvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pending awvalid=%b required=1", awvalid);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (awvalid !== 1'b0 || wvalid !== 1'b0 || arvalid !== 1'b0
        || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async aw=%b w=%b ar=%b rdy=%b required=0 0 0 0",
               awvalid, wvalid, arvalid, req_ready);
    end
    exp_w.delete();
    exp_err.delete();
    ref_mem = saved;
    aw_hold = 0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (idle !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_idle idle=%b required=1", idle);
    end
    act = 0;
    repeat (10) begin
      @(negedge clk);
      if (awvalid !== 1'b0 || wvalid !== 1'b0 || arvalid !== 1'b0) act = 1;
    end
    n_checks++;
    if (act || wlog_cnt != base) begin
      n_fail++;
      $display("FAIL rmid_quiet activity=%b writes=%0d required=0 0",
               act, wlog_cnt - base);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] exp;
    bit ok;
    s_rnd = 1;
    for (int i = 0; i < 200; i++) begin
      a = 32'($urandom_range(47) * 4);
      if ($urandom_range(99) < 60) begin
        cpu_issue(1'b1, a, $urandom, 4'($urandom), exp);
      end else begin
        cpu_issue(1'b0, a, 32'h0, 4'h0, exp);
        wait_read(ok);
        n_checks++;
        if (!ok) begin
          n_fail++;
          $display("FAIL rand_load_timeout addr=%h rv=%b required=1",
                   a, read_valid);
        end else if (read_data !== exp) begin
          n_fail++;
          $display("FAIL rand_load addr=%h got=%h required=%h",
                   a, read_data, exp);
        end
        repeat ($urandom_range(2)) @(negedge clk);
        ack_read();
      end
      repeat ($urandom_range(2)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle("rand_drain");
    n_checks++;
    if (exp_w.size() != 0 || exp_err.size() != 0) begin
      n_fail++;
      $display("FAIL rand_leftover writes=%0d errors=%0d required=0 0",
               exp_w.size(), exp_err.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_posted_burst();
    test_raw();
    test_split();
    test_errors();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/holy_no_cache_wbuf.md
# holy_no_cache_wbuf

Parametrised uncached CPU-to-AXI-Lite bridge, the successor of the single-transaction no-cache path. It sits between the core's load/store request port and the AXI-Lite fabric used for peripherals and uncached memory. New behaviour over the previous generation:
- a posted-write buffer of configurable depth;
- strict read-after-write ordering;
- configurable address/data width;
- bus error reporting;
- an idle flag for fences.

## Interface
- ADDR_WIDTH, 32, address width of CPU and AXI side
- DATA_WIDTH, 32, data width (32 or 64); STRB_WIDTH = DATA_WIDTH/8
- WBUF_DEPTH, 4, posted-write FIFO entries (power of 2, >= 2)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- address  in  ADDR_WIDTH  request address
- write_data  in  DATA_WIDTH  store data
- byte_enable  in  STRB_WIDTH  store byte lanes
- req_valid  in  1  request valid
- req_write  in  1  1 = store, 0 = load
- req_ready  out  1  request accepted when req_valid & req_ready
- read_data  out  DATA_WIDTH  load data
- read_valid  out  1  load data valid, held until read_ack
- read_ack  in  1  CPU consumed read_data
- idle  out  1  FIFO empty, no read pending, engine IDLE
- error_valid  out  1  one-cycle pulse on non-OKAY response
- error_write  out  1  error came from a write (1) or read (0)
- error_addr  out  ADDR_WIDTH  address of the failing transaction
- axi_lite_aw{addr,valid}/awready, w{data,strb,valid}/wready, bresp/bvalid/bready, ar{addr,valid}/arready, rdata/rresp/rvalid/rready: standard AXI-Lite master, widths per parameters, resp 2 bits

## Operation
- Write FIFO holds {addr, data, strb}. A store is accepted into the FIFO when req_valid & req_ready & req_write. The store is complete from the CPU's view on acceptance.
- Read-pending register holds one load address. It is loaded when req_valid & req_ready & !req_write.
- req_ready = !rst & !read_pending & !read_valid & (fifo_count < WBUF_DEPTH). It does not depend on req_valid or req_write.
- Engine FSM states:
  - IDLE
  - WRITE: awvalid/wvalid driven from the FIFO head
  - WRESP: bready = 1
  - RADDR: arvalid = 1
  - RDATA: rready = 1
- IDLE transitions:
  - FIFO non-empty -> WRITE. Writes have priority.
  - else, read pending -> RADDR.
- A read is therefore issued only after every earlier store has received its B response.
- WRITE:
  - awvalid and wvalid rise together.
  - Each drops independently after its own handshake.
  - When both handshakes are done -> WRESP.
- WRESP: on bvalid, pop the FIFO and go to IDLE. If bresp != OKAY, pulse error_valid with error_write = 1 and error_addr = entry addr.
- RADDR: on arready -> RDATA.
- RDATA: on rvalid, register rdata into read_data, set read_valid, clear read_pending, go to IDLE. If rresp != OKAY, the error pulse (error_write = 0) fires in the same cycle read_valid rises; data is still returned.
- read_valid and read_data hold until read_ack; read_valid clears the cycle after read_ack. read_ack while read_valid = 0 is ignored.
- FIFO push and pop in the same cycle leave the count unchanged. Full FIFO deasserts req_ready.
- FIFO pointers are log2(WBUF_DEPTH)+1 bits and wrap naturally. Full = MSBs differ and low bits are equal.

## Timing
- Reset values: all AXI valid/ready outputs 0, req_ready 0 while rst is high, read_valid 0, error_valid 0, idle 1, read_data 0, error_addr 0, FSM IDLE, FIFO empty, read_pending 0.
- Reset mid-transaction: all AXI outputs drop asynchronously. FIFO contents and any pending read are discarded, with no replay after reset.
- Store latency: accepted at T; awvalid/wvalid high at T+1 if the engine is IDLE with the FIFO empty.
- Load latency, FIFO empty: accepted at T, arvalid at T+1. With arready at T+1, rready at T+2; with rvalid at T+2, read_valid at T+3.
- AXI valids never drop before their handshake. Addresses and data are stable while valid is high.
- idle is combinational from registered state.

## Test plan
- Single load, zero-wait slave: load at 0x1000 at T, slave returns 0xDEADBEEF -> arvalid at T+1, read_valid at T+3 with 0xDEADBEEF, held until read_ack.
- Posted burst: 4 stores (0x0..0xC, data 1..4) back to back with slave awready held low -> req_ready is 1 for 4 acceptances and then 0. Releasing the slave produces AW/W in order 1..4 and req_ready returns.
- RAW ordering: store 0x55 to 0x20, then load 0x20 -> arvalid does not rise until bvalid for the store; load returns 0x55.
- Split handshake: wready 3 cycles after awready -> awvalid drops after its handshake and wvalid is held. bready rises only after both handshakes.
- Errors: bresp = SLVERR on a store to 0x40 -> one-cycle error_valid, error_write = 1, error_addr = 0x40. rresp = DECERR on a load from 0x80 -> error_write = 0, read_valid still asserted.
- Reset mid-burst: rst asserted with 2 stores queued and AW pending -> awvalid drops immediately. After release, idle = 1 and no AXI activity occurs.
